serial_rx_loader: RTL and testbench

Serial-to-parallel frame receiver that sits directly upstream of the parallel `register` stage. It samples a start/data/stop serial line on qualified clock edges and assembles `Size` data bits, LSB first. On a valid stop bit it presents the word on `data` and pulses `load` for one cycle. `data` connects to the register's `D` input and `load` connects to its `en` input.

---
 rtl/serial_rx_loader.sv | 86 ++++++++
 tb/tb_serial_rx_loader.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_rx_loader.sv
// serial_rx_loader: start/data/stop serial frame receiver feeding a parallel
// register. Bits are sampled on falling clk edges qualified by sample_en and
// assembled LSB first; a good stop bit presents the word on data and pulses
// load for one clk cycle, a bad stop bit sets the sticky frame_err flag.
module serial_rx_loader #(
  parameter int Size = 8
) (
  input  logic            clk,
  input  logic            clr_n,
  input  logic            sample_en,
  input  logic            rxd,
  output logic [Size-1:0] data,
  output logic            load,
  output logic            busy,
  output logic            frame_err
);

  localparam int CntW = $clog2(Size + 1);
  localparam logic [CntW-1:0] LastBit = CntW'(Size - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    STOP
  } state_t;

  state_t          state;
  logic [Size-1:0] shift;
  logic [CntW-1:0] cnt;

  // Frame FSM with registered outputs; everything moves on the falling edge.
  // NOTE: sequential state uses non-blocking assignments so every flop sees
  // the pre-edge values of the others, independent of statement order.
  always_ff @(negedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state     <= IDLE;
      shift     <= '0;
      cnt       <= '0;
      data      <= '0;
      load      <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      // load is a strobe: it falls on the edge after it rose, whatever else
      // happens, so it can never span more than one clk cycle.
      load <= 1'b0;
      if (sample_en) begin
        unique case (state)
          IDLE: begin
            if (!rxd) begin
              state     <= DATA;
              busy      <= 1'b1;
              cnt       <= '0;
              frame_err <= 1'b0;
            end
          end
          DATA: begin
            // Newest bit enters at the MSB, so after Size shifts the first
            // received bit sits at bit 0 (LSB-first line order).
            shift <= (shift >> 1) | (Size'(rxd) << (Size - 1));
            cnt   <= cnt + CntW'(1);
            if (cnt == LastBit) begin
              state <= STOP;
            end
          end
          STOP: begin
            // Stop sample is consumed here and never doubles as a start bit.
            if (rxd) begin
              data <= shift;
              load <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_rx_loader.sv
// Bench for serial_rx_loader: directed frames driven bit by bit, a frame-level
// reference model built from the sampled line, a per-cycle compare process,
// and a few literal expectations for the directed scenarios.
module tb_serial_rx_loader;

  localparam int SIZE = 8;

  logic            clk;
  logic            clr_n;
  logic            sample_en;
  logic            rxd;
  logic [SIZE-1:0] data;
  logic            load;
  logic            busy;
  logic            frame_err;

  // Downstream register that the receiver feeds (D = data, en = load).
  logic [SIZE-1:0] q;

  int n_checks = 0;
  int n_pass   = 0;
  int load_cnt = 0;
  int busy_cnt = 0;

  serial_rx_loader #(.Size(SIZE)) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .sample_en (sample_en),
    .rxd       (rxd),
    .data      (data),
    .load      (load),
    .busy      (busy),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk or negedge clr_n) begin
    if (!clr_n) q <= '0;
    else if (load) q <= data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Works on the list of sampled line values: an idle-line 0 opens a frame,
  // the next SIZE samples are the data bits, the one after that is the stop.
  bit              m_in_frame;
  bit              m_bits[$];
  logic [SIZE-1:0] m_data;
  bit              m_load;
  bit              m_busy;
  bit              m_err;
  logic [SIZE-1:0] m_q;

  always @(negedge clk or negedge clr_n) begin
    if (!clr_n) begin
      m_in_frame = 0;
      m_bits.delete();
      m_data = '0;
      m_load = 0;
      m_busy = 0;
      m_err  = 0;
      m_q    = '0;
    end else begin
      if (m_load) m_q = m_data;
      m_load = 0;
      if (sample_en) begin
        if (!m_in_frame) begin
          if (rxd == 1'b0) begin
            m_in_frame = 1;
            m_bits.delete();
            m_err = 0;
          end
        end else if (m_bits.size() < SIZE) begin
          m_bits.push_back(rxd);
        end else begin
          if (rxd) begin
            for (int i = 0; i < SIZE; i++) m_data[i] = m_bits[i];
            m_load = 1;
          end else begin
            m_err = 1;
          end
          m_in_frame = 0;
        end
      end
      m_busy = m_in_frame;
    end
  end

  // Compare on rising edges, half a cycle away from the falling active edge.
  always @(posedge clk) begin
    if (clr_n) begin
      check("data", 32'(data), 32'(m_data));
      check("load", 32'(load), 32'(m_load));
      check("busy", 32'(busy), 32'(m_busy));
      check("frame_err", 32'(frame_err), 32'(m_err));
      check("q", 32'(q), 32'(m_q));
    end
  end

  always @(posedge clk) begin
    if (load) load_cnt++;
    if (busy) busy_cnt++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic sample(input bit b, input int gap, input bit tog);
    for (int i = 0; i < gap; i++) begin
      @(posedge clk);
      sample_en = 1'b0;
      if (tog) rxd = ~rxd;
    end
    @(posedge clk);
    sample_en = 1'b1;
    rxd       = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      sample_en = 1'b0;
      rxd       = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [SIZE-1:0] w, input bit stop, input int gap, input bit tog);
    sample(1'b0, gap, tog);
    for (int i = 0; i < SIZE; i++) sample(w[i], gap, tog);
    sample(stop, gap, tog);
  endtask

  task automatic clear_counts();
    @(negedge clk);
    load_cnt = 0;
    busy_cnt = 0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [SIZE-1:0] w81;
    w81       = 8'h81;
    clr_n     = 1'b0;
    sample_en = 1'b0;
    rxd       = 1'b1;
    repeat (3) @(posedge clk);
    #2 clr_n = 1'b1;
    idle(3);

    // Good frame 0xA5, sampling every cycle.
    clear_counts();
    send_frame(8'hA5, 1'b1, 0, 1'b0);
    idle(3);
    check("t2_load_pulses", 32'(load_cnt), 32'd1);
    check("t2_busy_cycles", 32'(busy_cnt), 32'd9);
    check("t2_data", 32'(data), 32'hA5);
    check("t2_q", 32'(q), 32'hA5);

    // Asynchronous reset with no clock edge in between.
    @(posedge clk);
    #2 clr_n = 1'b0;
    #1;
    check("t1_data", 32'(data), 32'h0);
    check("t1_load", 32'(load), 32'h0);
    check("t1_busy", 32'(busy), 32'h0);
    check("t1_frame_err", 32'(frame_err), 32'h0);
    #1 clr_n = 1'b1;
    idle(2);

    // Gapped sampling (every 4th cycle) with line toggles between samples.
    clear_counts();
    send_frame(8'h3C, 1'b1, 3, 1'b1);
    idle(3);
    check("t3_load_pulses", 32'(load_cnt), 32'd1);
    check("t3_data", 32'(data), 32'h3C);

    // Framing error on 0x5A.
    clear_counts();
    send_frame(8'h5A, 1'b0, 0, 1'b0);
    idle(3);
    check("t4_load_pulses", 32'(load_cnt), 32'd0);
    check("t4_frame_err", 32'(frame_err), 32'h1);
    check("t4_data_kept", 32'(data), 32'h3C);
    check("t4_busy", 32'(busy), 32'h0);

    // Error clears on the 0x81 start bit; 0x7E follows back to back.
    clear_counts();
    sample(1'b0, 0, 1'b0);
    @(negedge clk);
    #1 check("t5_err_cleared", 32'(frame_err), 32'h0);
    for (int i = 0; i < SIZE; i++) sample(w81[i], 0, 1'b0);
    sample(1'b1, 0, 1'b0);
    @(negedge clk);
    #1 check("t5_data_81", 32'(data), 32'h81);
    send_frame(8'h7E, 1'b1, 0, 1'b0);
    idle(3);
    check("t5_load_pulses", 32'(load_cnt), 32'd2);
    check("t5_data_7e", 32'(data), 32'h7E);
    check("t5_q_7e", 32'(q), 32'h7E);

    // Reset after four data bits aborts the frame.
    clear_counts();
    sample(1'b0, 0, 1'b0);
    for (int i = 0; i < 4; i++) sample(1'b1, 0, 1'b0);
    @(posedge clk);
    sample_en = 1'b0;
    #2 clr_n = 1'b0;
    #1;
    check("t6_data", 32'(data), 32'h0);
    check("t6_busy", 32'(busy), 32'h0);
    check("t6_load", 32'(load), 32'h0);
    #1 clr_n = 1'b1;
    idle(3);
    check("t6_no_load", 32'(load_cnt), 32'd0);
    send_frame(8'hC3, 1'b1, 1, 1'b0);
    idle(3);
    check("t6_data_c3", 32'(data), 32'hC3);
    check("t6_q_c3", 32'(q), 32'hC3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
